// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized line, mid-bit sampling,
// valid/ready payload hold with frame-error and overrun pulses.
module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_RATE  = 9600,
  parameter int CLK_FREQ   = 12_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sig,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  input  logic                  ready,
  output logic                  frame_err,
  output logic                  overrun
);

  localparam int PULSE_WIDTH      = CLK_FREQ / BAUD_RATE;
  localparam int HALF_PULSE_WIDTH = PULSE_WIDTH / 2;
  localparam int CW = $clog2(PULSE_WIDTH + 1);
  localparam int BW = $clog2(DATA_WIDTH + 1);

  localparam logic [CW-1:0] PW_M1 = CW'(PULSE_WIDTH - 1);
  localparam logic [CW-1:0] HP_M1 = CW'(HALF_PULSE_WIDTH - 1);
  localparam logic [BW-1:0] LAST  = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  state_t                state, state_n;
  logic                  sig_m, sig_s;
  logic [CW-1:0]         clk_cnt, clk_cnt_n;
  logic [BW-1:0]         bit_cnt, bit_cnt_n;
  logic [DATA_WIDTH-1:0] shift, shift_n;
  logic                  stop_ok, stop_bad;
  logic                  deliver, drop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_m <= 1'b1;
      sig_s <= 1'b1;
    end else begin
      sig_m <= sig;
      sig_s <= sig_m;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      clk_cnt <= '0;
      bit_cnt <= '0;
      shift   <= '0;
    end else begin
      state   <= state_n;
      clk_cnt <= clk_cnt_n;
      bit_cnt <= bit_cnt_n;
      shift   <= shift_n;
    end
  end

  always_comb begin
    state_n   = state;
    clk_cnt_n = clk_cnt;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    stop_ok   = 1'b0;
    stop_bad  = 1'b0;
    case (state)
      IDLE: begin
        if (!sig_s) begin
          state_n   = START;
          clk_cnt_n = HP_M1;
        end
      end
      START: begin
        if (clk_cnt == '0) begin
          if (!sig_s) begin
            state_n   = DATA;
            clk_cnt_n = PW_M1;
            bit_cnt_n = '0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          clk_cnt_n = clk_cnt - CW'(1);
        end
      end
      DATA: begin
        if (clk_cnt == '0) begin
          // LSB arrives first and ends up in bit 0 after the last shift
          shift_n   = {sig_s, shift[DATA_WIDTH-1:1]};
          clk_cnt_n = PW_M1;
          if (bit_cnt == LAST) state_n = STOP;
          else bit_cnt_n = bit_cnt + BW'(1);
        end else begin
          clk_cnt_n = clk_cnt - CW'(1);
        end
      end
      STOP: begin
        if (clk_cnt == '0) begin
          if (sig_s) begin
            stop_ok = 1'b1;
            state_n = IDLE;
          end else begin
            stop_bad = 1'b1;
            state_n  = BREAK;
          end
        end else begin
          clk_cnt_n = clk_cnt - CW'(1);
        end
      end
      BREAK: begin
        if (sig_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    deliver = stop_ok && (!valid || ready);
    drop    = stop_ok && valid && !ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      overrun   <= drop;
      if (deliver) begin
        data  <= shift;
        valid <= 1'b1;
      end else if (ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at a fast 16-clock bit time.
module tb_uart_rx;

  localparam int DW   = 8;
  localparam int BAUD = 100_000;
  localparam int CLKF = 1_600_000;
  localparam int PW   = CLKF / BAUD;
  localparam int H    = PW / 2;
  localparam int LAT  = 3 + H + (DW + 1) * PW;

  logic          clk = 1'b0;
  logic          rst;
  logic          sig;
  logic          ready;
  logic [DW-1:0] data;
  logic          valid;
  logic          frame_err;
  logic          overrun;

  always #5 clk = ~clk;

  uart_rx #(
    .DATA_WIDTH(DW),
    .BAUD_RATE (BAUD),
    .CLK_FREQ  (CLKF)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sig      (sig),
    .data     (data),
    .valid    (valid),
    .ready    (ready),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  int n_run = 0;
  int n_fail = 0;
  int cyc = 0;
  int t0 = 0;
  int rise_cyc = -1;
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  logic valid_q = 1'b0;
  logic ferr_q = 1'b0;
  logic ovr_q = 1'b0;
  logic [DW-1:0] sb[$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      valid_q = 1'b0;
      ferr_q  = 1'b0;
      ovr_q   = 1'b0;
    end else begin
      if (frame_err) begin
        ferr_cnt++;
        chk("ferr_width", 32'(ferr_q), 0);
      end
      if (overrun) begin
        ovr_cnt++;
        chk("ovr_width", 32'(ovr_q), 0);
      end
      if (valid && !valid_q) rise_cyc = cyc;
      if (valid && ready) begin
        if (sb.size() == 0) chk("sb_underflow", sb.size(), 1);
        else chk("sb_data", 32'(data), 32'(sb.pop_front()));
      end
      valid_q = valid;
      ferr_q  = frame_err;
      ovr_q   = overrun;
    end
  end

  task automatic hold(input logic b, input int n);
    sig = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [DW-1:0] v, input logic stop,
                            input int stop_len);
    t0 = cyc;
    hold(1'b0, PW);
    for (int i = 0; i < DW; i++) hold(v[i], PW);
    hold(stop, stop_len);
  endtask

  initial begin
    rst   = 1'b1;
    sig   = 1'b1;
    ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(valid), 0);
    chk("rst_data", 32'(data), 0);
    chk("rst_ferr", 32'(frame_err), 0);
    chk("rst_ovr", 32'(overrun), 0);
    rst = 1'b0;
    hold(1'b1, 5);

    // single frame, consumer always ready
    ready    = 1'b1;
    rise_cyc = -1;
    sb.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, PW);
    hold(1'b1, 20);
    chk("a5_latency",
        32'((rise_cyc - t0 >= LAT - 1) && (rise_cyc - t0 <= LAT + 1)), 1);
    chk("a5_valid_clr", 32'(valid), 0);
    chk("a5_ferr", ferr_cnt, 0);
    chk("a5_ovr", ovr_cnt, 0);

    // back-to-back with no consumer: second frame dropped
    ready = 1'b0;
    sb.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, PW);
    send_frame(8'hC3, 1'b1, PW);
    hold(1'b1, 20);
    chk("ovr_data", 32'(data), 32'h3C);
    chk("ovr_valid", 32'(valid), 1);
    chk("ovr_count", ovr_cnt, 1);
    ready = 1'b1;
    hold(1'b1, 3);
    chk("ovr_drain", 32'(valid), 0);

    // stop bit low for two bit times
    send_frame(8'h55, 1'b0, 2 * PW);
    chk("ferr_count", ferr_cnt, 1);
    chk("ferr_valid", 32'(valid), 0);
    hold(1'b1, PW);
    sb.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, PW);
    hold(1'b1, 20);
    chk("ferr_recover", sb.size(), 0);

    // short low glitch while idle
    hold(1'b0, 5);
    hold(1'b1, 2 * PW);
    chk("glitch_valid", 32'(valid), 0);
    chk("glitch_ferr", ferr_cnt, 1);
    chk("glitch_ovr", ovr_cnt, 1);
    sb.push_back(8'h96);
    send_frame(8'h96, 1'b1, PW);
    hold(1'b1, 20);
    chk("glitch_recover", sb.size(), 0);

    // reset in the middle of an 0xFF frame
    hold(1'b0, PW);
    hold(1'b1, 3 * PW);
    rst = 1'b1;
    hold(1'b1, 2);
    chk("mid_rst_valid", 32'(valid), 0);
    chk("mid_rst_data", 32'(data), 0);
    rst = 1'b0;
    hold(1'b1, 8 * PW);
    sb.push_back(8'h81);
    send_frame(8'h81, 1'b1, PW);
    hold(1'b1, 20);
    chk("rst_only_81", sb.size(), 0);
    chk("rst_data_81", 32'(data), 32'h81);

    // consumer accepts in the exact stop-sample cycle of the next frame
    ready = 1'b0;
    sb.push_back(8'h11);
    send_frame(8'h11, 1'b1, PW);
    hold(1'b1, 20);
    chk("hold_valid", 32'(valid), 1);
    chk("hold_data", 32'(data), 32'h11);
    sb.push_back(8'h22);
    fork
      send_frame(8'h22, 1'b1, PW);
      begin
        repeat (LAT - 1) @(posedge clk);
        #1 ready = 1'b1;
        @(posedge clk);
        #1 ready = 1'b0;
      end
    join
    hold(1'b1, 20);
    chk("same_cyc_data", 32'(data), 32'h22);
    chk("same_cyc_valid", 32'(valid), 1);
    chk("same_cyc_ovr", ovr_cnt, 1);
    ready = 1'b1;
    hold(1'b1, 3);
    chk("final_valid", 32'(valid), 0);
    chk("final_sb", sb.size(), 0);
    chk("final_ferr", ferr_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning number of data bits per frame, LSB first.
REQ-002 SHALL have parameter BAUD_RATE, default 9600, meaning line bit rate in bit/s.
REQ-003 SHALL have parameter CLK_FREQ, default 12_000_000, meaning clk frequency in Hz.
REQ-004 SHALL derive PULSE_WIDTH = CLK_FREQ/BAUD_RATE (1250 at defaults) and HALF_PULSE_WIDTH = PULSE_WIDTH/2 (625) as localparams.
REQ-005 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1, reset: one clock; reset is asynchronous and active-high.
REQ-007 SHALL have port sig, input, 1, asynchronous serial line; idle high.
REQ-008 SHALL have port data, output, DATA_WIDTH, last received frame payload.
REQ-009 SHALL have port valid, output, 1, data holds an unconsumed frame.
REQ-010 SHALL have port ready, input, 1, consumer accepts data when valid && ready.
REQ-011 SHALL have port frame_err, output, 1, one-cycle pulse on bad stop bit.
REQ-012 SHALL have port overrun, output, 1, one-cycle pulse when a good frame is dropped.

Function
REQ-013 SHALL pass sig through a 2-flop synchronizer (both flops reset to 1); sig_s below is the second flop output.
REQ-014 SHALL implement states IDLE, START, DATA, STOP, BREAK with one down-counter clk_cnt and one bit counter bit_cnt.
REQ-015 IDLE: on sig_s==0 -> START, clk_cnt <= HALF_PULSE_WIDTH-1.
REQ-016 START: decrement clk_cnt; at 0, sig_s==0 -> DATA, clk_cnt <= PULSE_WIDTH-1, bit_cnt <= 0; sig_s==1 -> IDLE, no flag (glitch reject).
REQ-017 DATA: decrement clk_cnt; at 0, store sig_s into shift bit bit_cnt, reload PULSE_WIDTH-1; after sample with bit_cnt==DATA_WIDTH-1 -> STOP, else bit_cnt+1.
REQ-018 STOP: decrement clk_cnt; at 0, sig_s==1 -> deliver per REQ-019/020, -> IDLE; sig_s==0 -> frame_err pulse next cycle, frame discarded, -> BREAK.
REQ-019 Delivery with valid==0, or valid==1 && ready==1 in the same cycle: data <= shift register, valid <= 1 next cycle, no overrun.
REQ-020 Delivery with valid==1 && ready==0: overrun pulses 1 cycle, data and valid unchanged, new frame discarded.
REQ-021 BREAK: stay until sig_s==1, then -> IDLE; no new start detected while line held low.
REQ-022 valid SHALL stay high, data stable, until a cycle with ready==1; valid clears on the next edge unless REQ-019 reloads it.
REQ-023 ready SHALL be ignored while valid==0.
REQ-024 Latency: valid rises 2 + HALF_PULSE_WIDTH + (DATA_WIDTH+1)*PULSE_WIDTH + 1 cycles (+/-1) after sig falling edge (11878 at defaults).
REQ-025 frame_err and overrun SHALL never be high more than one consecutive cycle per frame.
REQ-026 Unreachable state encodings SHALL return to IDLE.

Reset
REQ-027 rst high SHALL immediately force state IDLE, valid 0, data 0, frame_err 0, overrun 0, counters 0, synchronizer flops 1, regardless of clock.
REQ-028 Reset mid-frame SHALL discard the partial frame; after release, reception restarts only on a new falling edge of sig_s.

Verification
REQ-029 Frame 0xA5 with valid stop, ready=1 -> valid one cycle, data=0xA5 at cycle ~11878 after start edge, no flags.
REQ-030 Two back-to-back frames 0x3C, 0xC3 with ready=0 -> data stays 0x3C, valid stays 1, overrun pulses once at second stop sample.
REQ-031 Frame 0x55 with stop bit driven 0 for 2 bit times -> frame_err one pulse, valid stays 0, no new frame until line high then next start.
REQ-032 sig low pulse of 300 cycles in idle -> no valid, no flags, FSM back in IDLE.
REQ-033 rst asserted mid-DATA of frame 0xFF, released, then frame 0x81 -> only 0x81 delivered.
REQ-034 valid high with 0x11 held, ready asserted exactly in the stop-sample cycle of frame 0x22 -> data=0x22, valid stays 1, overrun 0.
